// File: rtl/soc_system_sysid_regs.sv
// -----------------------------------------------------------------------------
// soc_system_sysid_regs
// System-ID / info slave for the HPS lightweight Avalon-MM bridge. Holds eight
// 32-bit words: build identity, clock frequency, a R/W scratch word and an
// optional 64-bit uptime counter with an atomic high-word snapshot.
//
// Build option: define SYSID_UPTIME_EN to include the uptime counter, its
// shadow, the wrap flag and the CONTROL word. Without it, addresses 5-7 read 0
// and ignore writes.
//
// Ports
//   clock          in   1   rising-edge clock
//   reset_n        in   1   asynchronous active-low reset
//   address        in   3   word address
//   read           in   1   read request (no waitrequest)
//   write          in   1   write request (no waitrequest)
//   writedata      in  32   write data
//   byteenable     in   4   write byte lanes (SCRATCH only)
//   readdata       out 32   read data, valid while readdatavalid=1
//   readdatavalid  out  1   one pulse per accepted read, READ_LATENCY later
//
// Map: 0 SYSID | 1 TIMESTAMP | 2 BUILD_VER | 3 CLK_FREQ_HZ | 4 SCRATCH |
//      5 UPTIME_LO | 6 UPTIME_HI_SNAP | 7 CONTROL {30'b0, wrap_flag, 1'b0}
// -----------------------------------------------------------------------------
module soc_system_sysid_regs #(
    parameter logic [31:0] SYSID        = 32'hACD51302,
    parameter logic [31:0] TIMESTAMP    = 32'h557474E0,
    parameter logic [31:0] BUILD_VER    = 32'h00010000,
    parameter logic [31:0] CLK_FREQ_HZ  = 32'd50000000,
    parameter int          READ_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    generate
        if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_latency
            $error("soc_system_sysid_regs: READ_LATENCY must be in 1..3");
        end
    endgenerate

    // A read that collides with a write is dropped; the write wins.
    logic w_rd_accept;
    logic w_wr_scratch;
    assign w_rd_accept  = read & ~write;
    assign w_wr_scratch = write & (address == 3'd4);

    logic [31:0] r_scratch;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_scratch <= 32'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_wr_scratch && byteenable[i]) begin
                    r_scratch[8*i +: 8] <= writedata[8*i +: 8];
                end
            end
        end
    end

    logic [31:0] w_uptime_lo;
    logic [31:0] w_uptime_hi;
    logic [31:0] w_control;

`ifdef SYSID_UPTIME_EN
    logic [63:0] r_uptime;
    logic [31:0] r_shadow;
    logic        r_wrap_flag;
    logic        w_ctl_wr;
    logic        w_cnt_clear;
    logic        w_flag_w1c;
    logic        w_cnt_wrap;

    assign w_ctl_wr    = write & (address == 3'd7);
    assign w_cnt_clear = w_ctl_wr & writedata[0];
    assign w_flag_w1c  = w_ctl_wr & writedata[1];
    assign w_cnt_wrap  = &r_uptime;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_uptime    <= 64'd0;
            r_shadow    <= 32'd0;
            r_wrap_flag <= 1'b0;
        end else begin
            if (w_cnt_clear) begin
                r_uptime <= 64'd0;
            end else begin
                r_uptime <= r_uptime + 64'd1;
            end
            // Snapshot the high word alongside a low-word read so the pair
            // is coherent even if the low word carries before HI is read.
            if (w_rd_accept && address == 3'd5) begin
                r_shadow <= r_uptime[63:32];
            end
            // A wrap beats a simultaneous W1C; a clear suppresses the wrap.
            if (w_cnt_wrap && !w_cnt_clear) begin
                r_wrap_flag <= 1'b1;
            end else if (w_flag_w1c) begin
                r_wrap_flag <= 1'b0;
            end
        end
    end

    assign w_uptime_lo = r_uptime[31:0];
    assign w_uptime_hi = r_shadow;
    assign w_control   = {30'd0, r_wrap_flag, 1'b0};
`else
    assign w_uptime_lo = 32'd0;
    assign w_uptime_hi = 32'd0;
    assign w_control   = 32'd0;
`endif

    logic [31:0] w_rd_data;

    always_comb begin
        w_rd_data = 32'd0;
        case (address)
            3'd0:    w_rd_data = SYSID;
            3'd1:    w_rd_data = TIMESTAMP;
            3'd2:    w_rd_data = BUILD_VER;
            3'd3:    w_rd_data = CLK_FREQ_HZ;
            3'd4:    w_rd_data = r_scratch;
            3'd5:    w_rd_data = w_uptime_lo;
            3'd6:    w_rd_data = w_uptime_hi;
            3'd7:    w_rd_data = w_control;
            default: w_rd_data = 32'd0;
        endcase
    end

    // Fixed-depth read pipeline: data is captured at accept time so that a
    // same-cycle register update never leaks into the returned value.
    logic [READ_LATENCY-1:0] r_pipe_vld;
    logic [31:0]             r_pipe_dat [READ_LATENCY];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipe_dat[i] <= 32'd0;
            end
        end else begin
            r_pipe_vld[0] <= w_rd_accept;
            r_pipe_dat[0] <= w_rd_data;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_dat[i] <= r_pipe_dat[i-1];
            end
        end
    end

    assign readdata      = r_pipe_dat[READ_LATENCY-1];
    assign readdatavalid = r_pipe_vld[READ_LATENCY-1];

endmodule

// File: tb/tb_soc_system_sysid_regs.sv
`timescale 1ns/1ps
module tb_soc_system_sysid_regs;

    localparam logic [31:0] P_SYSID = 32'hACD51302;
    localparam logic [31:0] P_TS    = 32'h557474E0;
    localparam logic [31:0] P_VER   = 32'h00010000;
    localparam logic [31:0] P_CLK   = 32'd50000000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = 32'd0;
    logic [3:0]  byteenable = 4'd0;
    logic [31:0] rd1, rd3;
    logic        v1, v3;

    always #5 clock = ~clock;

    soc_system_sysid_regs #(.READ_LATENCY(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .address(address), .read(read),
        .write(write), .writedata(writedata), .byteenable(byteenable),
        .readdata(rd1), .readdatavalid(v1)
    );

    soc_system_sysid_regs #(.READ_LATENCY(3)) dut3 (
        .clock(clock), .reset_n(reset_n), .address(address), .read(read),
        .write(write), .writedata(writedata), .byteenable(byteenable),
        .readdata(rd3), .readdatavalid(v3)
    );

    int n_edge = 0;
    always @(posedge clock) n_edge <= n_edge + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] d;
        int          due;
        logic [2:0]  a;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];
    exp_t e1, e3;

    // Reference model: counter value is derived from elapsed edges since the
    // last reset/clear/force; wrap flag is "set from edge m_wrap_edge on".
    logic [31:0] m_scratch = 32'd0;
    logic [31:0] m_shadow = 32'd0;
    int          m_base = 0;
    logic [63:0] m_off = 64'd0;
    int          m_wrap_edge = -1;
    logic [63:0] f_val;

    function automatic logic [63:0] m_count(int k);
        return m_off + 64'(k - m_base);
    endfunction

    function automatic logic [31:0] m_read(logic [2:0] a, int k);
        logic [63:0] c;
        logic        flag;
        c = m_count(k);
        flag = (m_wrap_edge >= 0) && (k >= m_wrap_edge);
        case (a)
            3'd0: return P_SYSID;
            3'd1: return P_TS;
            3'd2: return P_VER;
            3'd3: return P_CLK;
            3'd4: return m_scratch;
`ifdef SYSID_UPTIME_EN
            3'd5: return c[31:0];
            3'd6: return m_shadow;
            3'd7: return {30'd0, flag, 1'b0};
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic issue(bit rd, bit wr, logic [2:0] a, logic [31:0] d, logic [3:0] be);
        int k;
        exp_t e;
        logic [63:0] c;
        k = n_edge;
        address = a; read = rd; write = wr; writedata = d; byteenable = be;
        if (rd && !wr) begin
            e.d = m_read(a, k);
            e.a = a;
            e.due = k + 1; q1.push_back(e);
            e.due = k + 3; q3.push_back(e);
`ifdef SYSID_UPTIME_EN
            if (a == 3'd5) begin
                c = m_count(k);
                m_shadow = c[63:32];
            end
`endif
        end
        if (wr) begin
            if (a == 3'd4) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) m_scratch[8*i +: 8] = d[8*i +: 8];
            end
`ifdef SYSID_UPTIME_EN
            if (a == 3'd7) begin
                if (d[1] && m_wrap_edge >= 0 && m_wrap_edge <= k) m_wrap_edge = -1;
                if (d[0]) begin
                    if (m_wrap_edge == k + 1) m_wrap_edge = -1;
                    m_base = k + 1;
                    m_off = 64'd0;
                end
            end
`endif
        end
        @(posedge clock); #2;
        read = 1'b0; write = 1'b0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) issue(1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_valid_lat1", {31'd0, v1}, 32'd0);
        chk("rst_valid_lat3", {31'd0, v3}, 32'd0);
        chk("rst_data_lat1", rd1, 32'd0);
        chk("rst_data_lat3", rd3, 32'd0);
        q1.delete();
        q3.delete();
        repeat (3) @(posedge clock);
        #2;
        reset_n = 1'b1;
        m_scratch = 32'd0;
        m_shadow = 32'd0;
        m_wrap_edge = -1;
        m_base = n_edge;
        m_off = 64'd0;
    endtask

`ifdef SYSID_UPTIME_EN
    task force_count(logic [63:0] v);
        f_val = v;
        force dut1.r_uptime = f_val;
        force dut3.r_uptime = f_val;
        #1;
        release dut1.r_uptime;
        release dut3.r_uptime;
        m_off = v;
        m_base = n_edge;
        if (&v) m_wrap_edge = n_edge + 1;
    endtask
`endif

    always @(negedge clock) begin
        if (reset_n) begin
            if (q1.size() > 0 && q1[0].due < n_edge) begin
                checks++; errors++;
                $display("FAIL lat1_missing addr %0d: no readdatavalid, required at edge %0d", q1[0].a, q1[0].due);
                void'(q1.pop_front());
            end
            if (v1) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL lat1_unexpected: readdatavalid=1 data %h at edge %0d, required no pulse", rd1, n_edge);
                end else begin
                    e1 = q1.pop_front();
                    if (rd1 !== e1.d || n_edge != e1.due) begin
                        errors++;
                        $display("FAIL lat1_read addr %0d: got %h at edge %0d, required %h at edge %0d",
                                 e1.a, rd1, n_edge, e1.d, e1.due);
                    end
                end
            end
        end
    end

    always @(negedge clock) begin
        if (reset_n) begin
            if (q3.size() > 0 && q3[0].due < n_edge) begin
                checks++; errors++;
                $display("FAIL lat3_missing addr %0d: no readdatavalid, required at edge %0d", q3[0].a, q3[0].due);
                void'(q3.pop_front());
            end
            if (v3) begin
                checks++;
                if (q3.size() == 0) begin
                    errors++;
                    $display("FAIL lat3_unexpected: readdatavalid=1 data %h at edge %0d, required no pulse", rd3, n_edge);
                end else begin
                    e3 = q3.pop_front();
                    if (rd3 !== e3.d || n_edge != e3.due) begin
                        errors++;
                        $display("FAIL lat3_read addr %0d: got %h at edge %0d, required %h at edge %0d",
                                 e3.a, rd3, n_edge, e3.d, e3.due);
                    end
                end
            end
        end
    end

    initial begin
        @(posedge clock); #2;
        do_reset();

        // identity words straight out of reset
        issue(1'b1, 1'b0, 3'd0, 32'd0, 4'd0);
        issue(1'b1, 1'b0, 3'd1, 32'd0, 4'd0);
        idle(4);

        // partial-lane scratch write
        issue(1'b0, 1'b1, 3'd4, 32'h12345678, 4'b0101);
        issue(1'b1, 1'b0, 3'd4, 32'd0, 4'd0);
        idle(4);

        // back-to-back reads, no bubbles
        for (int i = 0; i < 4; i++) issue(1'b1, 1'b0, 3'(i), 32'd0, 4'd0);
        idle(5);

        // read+write collision: read dropped, write lands
        issue(1'b1, 1'b1, 3'd4, 32'hCAFEF00D, 4'hF);
        issue(1'b1, 1'b0, 3'd4, 32'd0, 4'd0);
        issue(1'b1, 1'b0, 3'd5, 32'd0, 4'd0);
        idle(4);

`ifdef SYSID_UPTIME_EN
        force_count(64'h0000_0001_FFFF_FFFF);
        issue(1'b1, 1'b0, 3'd5, 32'd0, 4'd0);
        issue(1'b1, 1'b0, 3'd6, 32'd0, 4'd0);
        idle(4);

        force_count(64'hFFFF_FFFF_FFFF_FFFF);
        idle(1);
        issue(1'b1, 1'b0, 3'd7, 32'd0, 4'd0);
        issue(1'b0, 1'b1, 3'd7, 32'h2, 4'hF);
        issue(1'b1, 1'b0, 3'd7, 32'd0, 4'd0);
        issue(1'b0, 1'b1, 3'd7, 32'h1, 4'hF);
        issue(1'b1, 1'b0, 3'd5, 32'd0, 4'd0);
        issue(1'b1, 1'b0, 3'd6, 32'd0, 4'd0);
        idle(4);
`endif

        // reset with reads in flight on the 3-deep pipeline
        issue(1'b1, 1'b0, 3'd0, 32'd0, 4'd0);
        issue(1'b1, 1'b0, 3'd1, 32'd0, 4'd0);
        do_reset();
        idle(6);
        issue(1'b1, 1'b0, 3'd5, 32'd0, 4'd0);
        issue(1'b1, 1'b0, 3'd4, 32'd0, 4'd0);
        idle(4);

        for (int n = 0; n < 400; n++) begin
            issue(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                  3'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)));
        end
        idle(6);

        chk("drain_lat1", 32'(q1.size()), 32'd0);
        chk("drain_lat3", 32'(q3.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
